// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two requesters (inst fetch, load/store), the
// arbiter and the single-port SRAM. The arbiter takes the slave view; the
// requesters and the memory together take the master view.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Instruction-fetch requester
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // Load/store requester
  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // Single-port synchronous SRAM
  logic              sram_en;
  logic [STRB_W-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch port and the load/store port. One grant per cycle,
// data preferred, with a streak counter that forces an inst grant after
// MAX_DATA_STREAK consecutive data grants while inst is waiting.
// Responses arrive exactly one cycle after the grant.
// Optional build macro: SRAM_ARB_PERF_EN adds three 32-bit perf counters.
module sram_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  sram_port_arbiter_if.slave      bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_inst_grants,
  output logic [31:0]             perf_data_grants,
  output logic [31:0]             perf_conflicts
`endif
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  // r_ready stays low for the first cycle after reset so that every output
  // is quiet in that cycle regardless of the request inputs.
  logic              r_ready;
  logic [3:0]        r_streak;
  logic              r_resp_valid;
  logic              r_resp_owner;   // 0 = inst, 1 = data

  logic              w_active;
  logic              w_inst_req;
  logic              w_data_req;
  logic              w_force_inst;
  logic              w_grant_data;
  logic              w_grant_inst;
  logic [3:0]        w_streak_nxt;
  logic              w_sram_en;
  logic [STRB_W-1:0] w_sram_we;
  logic [ADDR_W-1:0] w_sram_addr;
  logic [DATA_W-1:0] w_sram_wdata;
  logic              w_inst_data_ok;
  logic              w_data_data_ok;

  // Grant decision for the current cycle; requests ignored in or just after reset
  always_comb begin
    w_active     = resetn & r_ready;
    w_inst_req   = bus.inst_req & w_active;
    w_data_req   = bus.data_req & w_active;
    w_force_inst = w_inst_req & (r_streak == STREAK_MAX);
    w_grant_data = w_data_req & ~w_force_inst;
    w_grant_inst = w_inst_req & ~w_grant_data;
  end

  // Streak of data grants while inst waits: clears when inst is served or idle
  always_comb begin
    w_streak_nxt = r_streak;
    if (w_grant_inst || !w_inst_req) begin
      w_streak_nxt = 4'd0;
    end else if (w_grant_data && (r_streak != STREAK_MAX)) begin
      w_streak_nxt = r_streak + 4'd1;
    end else begin
      w_streak_nxt = r_streak;
    end
  end

  // SRAM command mux from the granted requester; all zero with no grant
  always_comb begin
    w_sram_en    = w_grant_inst | w_grant_data;
    w_sram_we    = {STRB_W{1'b0}};
    w_sram_addr  = {ADDR_W{1'b0}};
    w_sram_wdata = {DATA_W{1'b0}};
    if (w_grant_data) begin
      w_sram_addr  = bus.data_addr;
      w_sram_wdata = bus.data_wdata;
      if (bus.data_wr) begin
        w_sram_we = bus.data_wstrb;
      end else begin
        w_sram_we = {STRB_W{1'b0}};
      end
    end else if (w_grant_inst) begin
      w_sram_addr  = bus.inst_addr;
      w_sram_wdata = {DATA_W{1'b0}};
    end else begin
      w_sram_addr  = {ADDR_W{1'b0}};
    end
  end

  // Post-reset quiet cycle tracker
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  // Streak counter register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_streak <= 4'd0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end

  // Response tracker: which port owns the SRAM read data next cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= 1'b0;
    end else begin
      r_resp_valid <= w_sram_en;
      r_resp_owner <= w_grant_data;
    end
  end

  // Responses are masked while resetn is low so an in-flight access is dropped
  always_comb begin
    w_inst_data_ok = resetn & r_resp_valid & ~r_resp_owner;
    w_data_data_ok = resetn & r_resp_valid &  r_resp_owner;
  end

  assign bus.inst_addr_ok = w_grant_inst;
  assign bus.data_addr_ok = w_grant_data;
  assign bus.inst_data_ok = w_inst_data_ok;
  assign bus.data_data_ok = w_data_data_ok;
  assign bus.inst_rdata   = w_inst_data_ok ? bus.sram_rdata : {DATA_W{1'b0}};
  assign bus.data_rdata   = w_data_data_ok ? bus.sram_rdata : {DATA_W{1'b0}};
  assign bus.sram_en      = w_sram_en;
  assign bus.sram_we      = w_sram_we;
  assign bus.sram_addr    = w_sram_addr;
  assign bus.sram_wdata   = w_sram_wdata;

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] r_perf_inst;
  logic [31:0] r_perf_data;
  logic [31:0] r_perf_conf;

  // Free-running grant and conflict counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_perf_inst <= 32'd0;
      r_perf_data <= 32'd0;
      r_perf_conf <= 32'd0;
    end else begin
      r_perf_inst <= r_perf_inst + {31'd0, w_grant_inst};
      r_perf_data <= r_perf_data + {31'd0, w_grant_data};
      r_perf_conf <= r_perf_conf + {31'd0, (w_inst_req & w_data_req)};
    end
  end

  assign perf_inst_grants = r_perf_inst;
  assign perf_data_grants = r_perf_data;
  assign perf_conflicts   = r_perf_conf;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level reference of the grant
// rules, the one-cycle response latency and a byte-accurate memory image.
module tb_sram_port_arbiter;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] fetch_val;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] perf_i;
  logic [31:0] perf_d;
  logic [31:0] perf_c;
`endif

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef SRAM_ARB_PERF_EN
    ,
    .perf_inst_grants (perf_i),
    .perf_data_grants (perf_d),
    .perf_conflicts   (perf_c)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: byte writes, registered read data
  logic [31:0] mem [logic [31:0]];
  logic [31:0] sram_tmp;
  always @(posedge clk) begin
    if (bus.sram_en) begin
      sram_tmp = mem.exists(bus.sram_addr) ? mem[bus.sram_addr] : 32'h0;
      if (bus.sram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_we[b]) sram_tmp[b*8 +: 8] = bus.sram_wdata[b*8 +: 8];
        mem[bus.sram_addr] = sram_tmp;
      end else begin
        bus.sram_rdata <= sram_tmp;
      end
    end
  end

  task automatic idle();
    bus.inst_req   = 1'b0;
    bus.inst_addr  = 32'h0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = 4'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic drive_data(input logic wr, input logic [3:0] strb,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_wstrb = strb;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
  endtask

  task automatic test_reset();
    bus.sram_rdata = 32'h0;
    idle();
    resetn = 1'b0;
    bus.inst_req = 1'b1;
    drive_data(1'b1, 4'hF, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok,
         bus.sram_en, bus.sram_we} !== 9'h0) begin
      errors++;
      $display("FAIL reset_ctrl got %b required 0", {bus.inst_addr_ok, bus.inst_data_ok,
               bus.data_addr_ok, bus.data_data_ok, bus.sram_en, bus.sram_we});
    end
    checks++;
    if ({bus.sram_addr, bus.sram_wdata, bus.inst_rdata, bus.data_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_bus got %h %h required 0", bus.sram_addr, bus.sram_wdata);
    end
    tick();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.inst_data_ok,
         bus.data_data_ok} !== 5'h0) begin
      errors++;
      $display("FAIL reset_first_cycle got %b required 0", {bus.inst_addr_ok,
               bus.data_addr_ok, bus.sram_en, bus.inst_data_ok, bus.data_data_ok});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL reset_first_grant got %b required 01", {bus.inst_addr_ok, bus.data_addr_ok});
    end
    tick();
    idle();
    tick();
    tick();
  endtask

  task automatic test_inst_fetch();
    fetch_val = $urandom;
    drive_data(1'b1, 4'hF, 32'h1C00_0000, fetch_val);
    tick();
    idle();
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0000;
    @(negedge clk);
    checks++;
    if ({bus.inst_addr_ok, bus.sram_en, bus.sram_we} !== 6'b110000) begin
      errors++;
      $display("FAIL fetch_grant got ok=%b en=%b we=%b required 1 1 0",
               bus.inst_addr_ok, bus.sram_en, bus.sram_we);
    end
    checks++;
    if (bus.sram_addr !== 32'h1C00_0000) begin
      errors++;
      $display("FAIL fetch_addr got %h required 1c000000", bus.sram_addr);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10 || bus.inst_rdata !== fetch_val) begin
      errors++;
      $display("FAIL fetch_resp got ok=%b rdata=%h required 1 %h",
               bus.inst_data_ok, bus.inst_rdata, fetch_val);
    end
    tick();
  endtask

  task automatic test_store_load();
    drive_data(1'b1, 4'hF, 32'h100, 32'h1122_3344);
    tick();
    idle();
    tick();
    drive_data(1'b1, 4'b0010, 32'h100, 32'hAABB_CCDD);
    @(negedge clk);
    checks++;
    if (bus.sram_we !== 4'b0010 || bus.data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL store_we got we=%b ok=%b required 0010 1", bus.sram_we, bus.data_addr_ok);
    end
    tick();
    drive_data(1'b0, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.data_data_ok, bus.data_addr_ok, bus.sram_we} !== 6'b110000) begin
      errors++;
      $display("FAIL store_ack got ok=%b aok=%b we=%b required 1 1 0",
               bus.data_data_ok, bus.data_addr_ok, bus.sram_we);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'h1122_CC44) begin
      errors++;
      $display("FAIL load_after_store got ok=%b rdata=%h required 1 1122cc44",
               bus.data_data_ok, bus.data_rdata);
    end
    tick();
  endtask

  task automatic test_conflict();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0000;
    drive_data(1'b0, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.inst_addr_ok, bus.data_addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL conflict_grant got %b required 01", {bus.inst_addr_ok, bus.data_addr_ok});
    end
    tick();
    bus.data_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.inst_addr_ok, bus.data_data_ok, bus.inst_data_ok} !== 3'b110 ||
        bus.data_rdata !== 32'h1122_CC44) begin
      errors++;
      $display("FAIL conflict_retry got %b rdata=%h required 110 1122cc44",
               {bus.inst_addr_ok, bus.data_data_ok, bus.inst_data_ok}, bus.data_rdata);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({bus.inst_data_ok, bus.data_data_ok} !== 2'b10 || bus.inst_rdata !== fetch_val) begin
      errors++;
      $display("FAIL conflict_inst_resp got %b rdata=%h required 10 %h",
               {bus.inst_data_ok, bus.data_data_ok}, bus.inst_rdata, fetch_val);
    end
    tick();
  endtask

  task automatic test_starvation();
    string pat;
    pat = "DDDDIDDDDI";
    do_reset();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0000;
    drive_data(1'b0, 4'h0, 32'h100, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.inst_addr_ok, bus.data_addr_ok} !== {pat[i] == "I", pat[i] == "D"}) begin
        errors++;
        $display("FAIL starve_cycle%0d got inst/data ok=%b required %s",
                 i, {bus.inst_addr_ok, bus.data_addr_ok}, pat.substr(i, i));
      end
      tick();
    end
    idle();
`ifdef SRAM_ARB_PERF_EN
    @(negedge clk);
    checks++;
    if (perf_d !== 32'd8 || perf_i !== 32'd2 || perf_c !== 32'd10) begin
      errors++;
      $display("FAIL perf_counters got d=%0d i=%0d c=%0d required 8 2 10",
               perf_d, perf_i, perf_c);
    end
`endif
    tick();
  endtask

  task automatic test_reset_midflight();
    drive_data(1'b0, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL midflight_grant got %b required 1", bus.data_addr_ok);
    end
    tick();
    idle();
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.data_data_ok, bus.inst_data_ok, bus.sram_en} !== 3'b000 ||
        bus.data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL midflight_drop got ok=%b rdata=%h required 0 0",
               bus.data_data_ok, bus.data_rdata);
    end
    tick();
    resetn = 1'b1;
    drive_data(1'b0, 4'h0, 32'h100, 32'h0);
    @(negedge clk);
    checks++;
    if ({bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok,
         bus.sram_en, bus.sram_we} !== 9'h0 || bus.sram_addr !== 32'h0) begin
      errors++;
      $display("FAIL midflight_after got %b required 0", {bus.inst_addr_ok,
               bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok, bus.sram_en, bus.sram_we});
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL midflight_regrant got %b required 1", bus.data_addr_ok);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'h1122_CC44) begin
      errors++;
      $display("FAIL midflight_reload got ok=%b rdata=%h required 1 1122cc44",
               bus.data_data_ok, bus.data_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:7];
    int          streak;
    logic        i_pend, d_pend, exp_gi, exp_gd;
    logic        pv, po, pload;
    logic [31:0] prd;
    logic [3:0]  exp_we;
    int          idx;
    streak = 0; i_pend = 1'b0; d_pend = 1'b0;
    pv = 1'b0; po = 1'b0; pload = 1'b0; prd = 32'h0;
    for (int k = 0; k < 8; k++) ref_mem[k] = 32'h0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc < 8) begin
        bus.inst_req = 1'b0;
        drive_data(1'b1, 4'hF, 32'h2000 + 32'(cyc * 4), $urandom);
      end else begin
        if (!i_pend) begin
          bus.inst_req  = ($urandom_range(0, 99) < 60);
          bus.inst_addr = 32'h2000 + 32'($urandom_range(0, 7) * 4);
        end
        if (!d_pend) begin
          bus.data_req   = ($urandom_range(0, 99) < 70);
          bus.data_wr    = 1'($urandom_range(0, 1));
          bus.data_wstrb = 4'($urandom_range(0, 15));
          bus.data_addr  = 32'h2000 + 32'($urandom_range(0, 7) * 4);
          bus.data_wdata = $urandom;
        end
      end
      exp_gd = bus.data_req && !(bus.inst_req && streak == MAXS);
      exp_gi = bus.inst_req && !exp_gd;
      exp_we = (exp_gd && bus.data_wr) ? bus.data_wstrb : 4'h0;
      @(negedge clk);
      checks++;
      if ({bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.sram_we} !==
          {exp_gi, exp_gd, exp_gi | exp_gd, exp_we}) begin
        errors++;
        $display("FAIL rand_grant cyc%0d got %b required %b", cyc,
                 {bus.inst_addr_ok, bus.data_addr_ok, bus.sram_en, bus.sram_we},
                 {exp_gi, exp_gd, exp_gi | exp_gd, exp_we});
      end
      if (exp_gi || exp_gd) begin
        checks++;
        if (bus.sram_addr !== (exp_gd ? bus.data_addr : bus.inst_addr)) begin
          errors++;
          $display("FAIL rand_addr cyc%0d got %h", cyc, bus.sram_addr);
        end
      end
      checks++;
      if ({bus.inst_data_ok, bus.data_data_ok} !== {pv & ~po, pv & po}) begin
        errors++;
        $display("FAIL rand_resp cyc%0d got %b required %b", cyc,
                 {bus.inst_data_ok, bus.data_data_ok}, {pv & ~po, pv & po});
      end
      if (pv && pload) begin
        checks++;
        if ((po ? bus.data_rdata : bus.inst_rdata) !== prd) begin
          errors++;
          $display("FAIL rand_rdata cyc%0d got %h required %h", cyc,
                   po ? bus.data_rdata : bus.inst_rdata, prd);
        end
      end
      pv = exp_gi | exp_gd;
      po = exp_gd;
      pload = exp_gi || (exp_gd && !bus.data_wr);
      idx = int'((exp_gd ? bus.data_addr : bus.inst_addr) - 32'h2000) / 4;
      if (pv) begin
        prd = ref_mem[idx];
        if (exp_gd && bus.data_wr)
          for (int b = 0; b < 4; b++)
            if (bus.data_wstrb[b]) ref_mem[idx][b*8 +: 8] = bus.data_wdata[b*8 +: 8];
      end
      if (exp_gi || !bus.inst_req) streak = 0;
      else if (exp_gd && streak < MAXS) streak = streak + 1;
      i_pend = bus.inst_req && !exp_gi;
      d_pend = bus.data_req && !exp_gd;
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if ({bus.inst_data_ok, bus.data_data_ok} !== {pv & ~po, pv & po} ||
        (pv && pload && (po ? bus.data_rdata : bus.inst_rdata) !== prd)) begin
      errors++;
      $display("FAIL rand_drain got %b required %b", {bus.inst_data_ok, bus.data_data_ok},
               {pv & ~po, pv & po});
    end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_inst_fetch();
    test_store_load();
    test_conflict();
    test_starvation();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester (inst) and the load/store requester (data).
- Each requester uses a req/addr_ok/data_ok handshake.
- Each cycle the block grants at most one request. A starvation guard gives data priority over inst but never starves inst.
- It sits between the IF/EX-MEM stages and the unified memory.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- MAX_DATA_STREAK, 4, maximum number of consecutive data grants while inst is waiting; range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- inst_req  in  1  fetch request (read only)
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  1 = store
- data_wstrb  in  DATA_W/8  byte write enables for a store
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  load/store request accepted this cycle
- data_data_ok  out  1  load/store response valid; for a store it is an acknowledge only
- data_rdata  out  DATA_W  load read data
- sram_en  out  1  SRAM access enable
- sram_we  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid one cycle after sram_en

Behaviour:
- Grant logic is combinational in the request cycle.
  - grant_data = data_req & ~force_inst
  - grant_inst = inst_req & ~grant_data
  - force_inst = inst_req & (streak == MAX_DATA_STREAK)
- addr_ok equals the grant. A handshake completes when req & addr_ok are both high. A requester holds req, addr and wdata stable until addr_ok.
- SRAM drive:
  - sram_en = grant_inst | grant_data.
  - sram_addr, sram_wdata: muxed from the granted requester.
  - sram_we = data_wstrb when (grant_data & data_wr), else 0.
  - With no grant: sram_en = 0, sram_we = 0, and addr/wdata are don't-care.
- Streak counter (4-bit, reset 0):
  - Increments on grant_data while inst_req is high.
  - Clears on grant_inst, or whenever inst_req is low.
  - Saturates at MAX_DATA_STREAK.
- Response register: resp_valid and resp_owner (0 = inst, 1 = data), both reset 0.
  - On each clock: resp_valid <= sram_en, and resp_owner <= grant_data.
- Response outputs:
  - inst_data_ok = resp_valid & ~resp_owner.
  - data_data_ok = resp_valid & resp_owner.
  - inst_rdata = data_rdata = sram_rdata. These values are valid only while the matching data_ok is high.
- Latency is fixed: data_ok is asserted exactly 1 cycle after addr_ok. Throughput is 1 request per cycle. There is no response back-pressure; requesters must always accept data_ok.
- Simultaneous requests: data wins unless force_inst. The loser sees addr_ok = 0 and retries next cycle.
- Reset:
  - All registers clear.
  - All outputs are 0 during reset and in the first cycle after it. This includes data_ok; sram_en is 0 because req inputs are ignored while ~resetn.
  - A response in flight when reset asserts is dropped and no data_ok is issued.
- Store followed by a load to the same address in consecutive cycles: the load returns the new data, since the SRAM write completes before the next read.

Optional Feature:
- Macro SRAM_ARB_PERF_EN.
- When defined, the block adds three 32-bit outputs:
  - perf_inst_grants: counts grant_inst.
  - perf_data_grants: counts grant_data.
  - perf_conflicts: counts cycles where inst_req & data_req are both high.
- The counters clear on reset and wrap modulo 2^32.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Inst-only fetch: inst_req = 1, inst_addr = 0x1C000000. Required response: inst_addr_ok = 1 and sram_en = 1 with sram_we = 0 in the same cycle. Next cycle inst_data_ok = 1 and inst_rdata equals memory[0x1C000000].
- Store then load: data store to 0x100, wstrb = 0b0010, wdata = 0xAABBCCDD, then a load from 0x100 next cycle. Required response: sram_we = 0b0010 on the store, data_data_ok on each of the 2 following cycles, and load rdata byte1 = 0xCC.
- Conflict: inst_req and data_req both high for a single cycle. Required response: data granted, inst_addr_ok = 0. Next cycle inst is granted. The two data_ok pulses arrive in that order.
- Starvation guard: MAX_DATA_STREAK = 4, with inst_req and data_req held high for 10 cycles. Required grant pattern: D, D, D, D, I, D, D, D, D, I.
- Reset mid-flight: assert resetn = 0 the cycle after a data grant. Required response: no data_data_ok, and all outputs are 0 in the cycle after resetn returns high.
- Perf counters (with SRAM_ARB_PERF_EN): after the starvation scenario, perf_data_grants = 8, perf_inst_grants = 2, perf_conflicts = 10.
